string_led_sequencer: RTL and testbench

Downstream consumer of the string-LED register block. On a start strobe it reads pixel bytes from SRAM port 1 between w_first and w_last, repeating the range (w_count+1) times. It serialises each byte MSB-first as a WS2812-style one-wire waveform, then holds a latch gap. The progress output returns to the register block, which raises irq on its falling edge.

---
 rtl/string_led_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_string_led_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_led_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : string_led_sequencer                                         |
// | Description : Reads a range of pixel bytes from SRAM port 1, repeats the   |
// |               range (w_count+1) times and serialises every byte MSB-first  |
// |               as a WS2812-style one-wire waveform, then holds a latch gap. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module string_led_sequencer #(
  parameter int ASIZE       = 32,
  parameter int PSIZE       = 32,
  parameter int LATCH_TICKS = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             controller_en,
  input  logic [PSIZE-1:0] prescaler,
  input  logic             polarity,
  input  logic [3:0]       w_count,
  input  logic [ASIZE-1:0] w_first,
  input  logic [ASIZE-1:0] w_last,
  input  logic             start,
  output logic             progress,
  output logic             cs_n,
  output logic [ASIZE-1:0] addr,
  input  logic [7:0]       rdata,
  output logic             led_out
);

  localparam int LW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH0 = 3'd1,
    S_LOAD   = 3'd2,
    S_SHIFT  = 3'd3,
    S_LATCH  = 3'd4
  } state_t;

  state_t             state_q,     state_d;
  logic [PSIZE-1:0]   cnt_q,       cnt_d;
  logic [PSIZE-1:0]   presc_q,     presc_d;
  logic [ASIZE-1:0]   first_q,     first_d;
  logic [ASIZE-1:0]   last_q,      last_d;
  logic [3:0]         passes_q,    passes_d;
  logic [ASIZE-1:0]   addr_q,      addr_d;
  logic               cs_n_q,      cs_n_d;
  logic               progress_q,  progress_d;
  logic               level_q,     level_d;
  logic [7:0]         shreg_q,     shreg_d;
  logic [7:0]         pbuf_q,      pbuf_d;
  logic               have_next_q, have_next_d;
  logic [2:0]         bit_cnt_q,   bit_cnt_d;
  logic [1:0]         sub_q,       sub_d;
  logic [LW-1:0]      latch_cnt_q, latch_cnt_d;
  logic               first_rd_q,  first_rd_d;  // rdata holds the first byte
  logic               pf_rd_q,     pf_rd_d;     // rdata holds a prefetched byte

  logic               tick;
  logic               more;
  logic               fetch_next;
  logic [ASIZE-1:0]   nxt_addr;

  // Next-state logic: tick generator, fetch sequencing, bit serialiser
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    first_d     = first_q;
    last_d      = last_q;
    passes_d    = passes_q;
    addr_d      = addr_q;
    cs_n_d      = 1'b1;
    progress_d  = progress_q;
    shreg_d     = shreg_q;
    pbuf_d      = pbuf_q;
    have_next_d = have_next_q;
    bit_cnt_d   = bit_cnt_q;
    sub_d       = sub_q;
    latch_cnt_d = latch_cnt_q;
    first_rd_d  = (state_q == S_FETCH0);
    pf_rd_d     = !cs_n_q && (state_q != S_FETCH0);
    fetch_next  = 1'b0;

    tick     = (state_q != S_IDLE) && (cnt_q == presc_q);
    cnt_d    = (state_q == S_IDLE || tick) ? '0 : cnt_q + PSIZE'(1);
    // Another byte exists if the range continues or a further pass remains
    more     = (addr_q != last_q) || (passes_q != 4'd0);
    nxt_addr = (addr_q != last_q) ? addr_q + ASIZE'(1) : first_q;

    if (pf_rd_q) pbuf_d = rdata;

    case (state_q)
      S_IDLE: begin
        if (start && controller_en) begin
          state_d    = S_FETCH0;
          presc_d    = prescaler;
          first_d    = w_first;
          last_d     = w_last;
          passes_d   = w_count;
          addr_d     = w_first;
          cs_n_d     = 1'b0;
          progress_d = 1'b1;
          cnt_d      = '0;
        end
      end
      S_FETCH0: state_d = S_LOAD;
      S_LOAD: begin
        if (first_rd_q) begin
          shreg_d    = rdata;
          fetch_next = more;
        end
        // Wait for a tick so the first sub-tick has full length
        if (tick) begin
          state_d   = S_SHIFT;
          sub_d     = 2'd0;
          bit_cnt_d = 3'd7;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (sub_q != 2'd2) begin
            sub_d = sub_q + 2'd1;
          end else begin
            sub_d = 2'd0;
            if (bit_cnt_q != 3'd0) begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
            end else if (have_next_q) begin
              shreg_d     = pbuf_q;
              bit_cnt_d   = 3'd7;
              have_next_d = 1'b0;
              fetch_next  = more;
            end else begin
              state_d     = S_LATCH;
              latch_cnt_d = '0;
            end
          end
        end
      end
      S_LATCH: begin
        if (tick) begin
          if (latch_cnt_q == LW'(LATCH_TICKS - 1)) begin
            state_d    = S_IDLE;
            progress_d = 1'b0;
          end else begin
            latch_cnt_d = latch_cnt_q + LW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fetch_next) begin
      cs_n_d      = 1'b0;
      addr_d      = nxt_addr;
      have_next_d = 1'b1;
      if (addr_q == last_q) passes_d = passes_q - 4'd1;
    end

    // Losing the enable aborts immediately, without a latch gap
    if (state_q != S_IDLE && !controller_en) begin
      state_d     = S_IDLE;
      progress_d  = 1'b0;
      cs_n_d      = 1'b1;
      have_next_d = 1'b0;
      cnt_d       = '0;
    end

    level_d = (state_d == S_SHIFT) &&
              ((sub_d == 2'd0) || ((sub_d == 2'd1) && shreg_d[7]));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      presc_q     <= '0;
      first_q     <= '0;
      last_q      <= '0;
      passes_q    <= '0;
      addr_q      <= '0;
      cs_n_q      <= 1'b1;
      progress_q  <= 1'b0;
      level_q     <= 1'b0;
      shreg_q     <= '0;
      pbuf_q      <= '0;
      have_next_q <= 1'b0;
      bit_cnt_q   <= '0;
      sub_q       <= '0;
      latch_cnt_q <= '0;
      first_rd_q  <= 1'b0;
      pf_rd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      first_q     <= first_d;
      last_q      <= last_d;
      passes_q    <= passes_d;
      addr_q      <= addr_d;
      cs_n_q      <= cs_n_d;
      progress_q  <= progress_d;
      level_q     <= level_d;
      shreg_q     <= shreg_d;
      pbuf_q      <= pbuf_d;
      have_next_q <= have_next_d;
      bit_cnt_q   <= bit_cnt_d;
      sub_q       <= sub_d;
      latch_cnt_q <= latch_cnt_d;
      first_rd_q  <= first_rd_d;
      pf_rd_q     <= pf_rd_d;
    end
  end

  assign progress = progress_q;
  assign cs_n     = cs_n_q;
  assign addr     = addr_q;
  assign led_out  = level_q ^ polarity;

endmodule
`default_nettype wire

// File: tb/tb_string_led_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_string_led_sequencer                                      |
// | Description : Scoreboard bench for string_led_sequencer (ASIZE=4).         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_string_led_sequencer;

  localparam int ASIZE = 4;
  localparam int PSIZE = 8;
  localparam int LATCH = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             controller_en = 1'b1;
  logic [PSIZE-1:0] prescaler = '0;
  logic             polarity = 1'b0;
  logic [3:0]       w_count = '0;
  logic [ASIZE-1:0] w_first = '0;
  logic [ASIZE-1:0] w_last = '0;
  logic             start = 1'b0;
  logic             progress;
  logic             cs_n;
  logic [ASIZE-1:0] addr;
  logic [7:0]       rdata = '0;
  logic             led_out;

  logic [7:0] mem [16];

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_addr [$];
  bit         exp_led  [$];

  string_led_sequencer #(
    .ASIZE(ASIZE), .PSIZE(PSIZE), .LATCH_TICKS(LATCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .controller_en(controller_en),
    .prescaler(prescaler), .polarity(polarity), .w_count(w_count),
    .w_first(w_first), .w_last(w_last), .start(start),
    .progress(progress), .cs_n(cs_n), .addr(addr), .rdata(rdata),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  // SRAM port 1: data valid the cycle after cs_n is low
  always @(posedge clk) if (!cs_n) rdata <= mem[addr];

  // Expected fetch addresses and per-cycle line levels from the first bit on
  task automatic build_expect(input int presc, input int first, input int last, input int cnt);
    int a;
    logic [7:0] v;
    exp_addr.delete();
    exp_led.delete();
    for (int p = 0; p <= cnt; p++) begin
      a = first;
      while (1) begin
        exp_addr.push_back(4'(a));
        v = mem[a];
        for (int b = 7; b >= 0; b--)
          for (int s = 0; s < 3; s++)
            for (int c = 0; c <= presc; c++)
              exp_led.push_back(s == 0 ? 1'b1 : (s == 1 ? v[b] : 1'b0));
        if (a == last) break;
        a = (a + 1) % 16;
      end
    end
    for (int c = 0; c < LATCH * (presc + 1); c++) exp_led.push_back(1'b0);
  endtask

  // Starts a transfer and follows it cycle by cycle against the scoreboard.
  // abort_at / rst_at: bit-cycle count at which enable drops / reset asserts.
  // ign_at: cycle index at which a (to be ignored) start pulse is driven.
  task automatic run_case(input string tag, input int presc, input int pol,
                          input int first, input int last, input int cnt,
                          input int abort_at, input int ign_at, input int rst_at);
    bit started, aborting, finished, early_exit, e;
    int n;
    logic [3:0] ea;
    prescaler = PSIZE'(presc);
    polarity  = pol[0];
    w_first   = 4'(first);
    w_last    = 4'(last);
    w_count   = 4'(cnt);
    build_expect(presc, first, last, cnt);
    started = 0; aborting = 0; finished = 0; early_exit = 0; n = 0;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4000; k++) begin
      if (k > 0) @(negedge clk);
      start = (k == ign_at);
      if (k == ign_at) begin
        w_first = 4'd3;
        w_last  = 4'd3;
      end
      if (aborting) begin
        checks++;
        if (progress !== 1'b0 || cs_n !== 1'b1 || led_out !== pol[0]) begin
          errors++;
          $display("FAIL %s abort: progress=%b cs_n=%b led_out=%b required 0 1 %b",
                   tag, progress, cs_n, led_out, pol[0]);
        end
        controller_en = 1'b1;
        early_exit = 1;
        break;
      end
      if (k == 0) begin
        checks++;
        if (progress !== 1'b1) begin
          errors++;
          $display("FAIL %s progress_rise: got %b required 1", tag, progress);
        end
      end
      if (cs_n === 1'b0) begin
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL %s fetch: unexpected fetch of addr %0d", tag, addr);
        end else begin
          ea = exp_addr.pop_front();
          if (addr !== ea) begin
            errors++;
            $display("FAIL %s addr: got %0d required %0d", tag, addr, ea);
          end
        end
      end
      if (!started && (led_out ^ pol[0])) started = 1;
      if (started) begin
        if (exp_led.size() > 0) begin
          e = exp_led.pop_front();
          checks++;
          if (led_out !== (e ^ pol[0])) begin
            errors++;
            $display("FAIL %s led_out[%0d]: got %b required %b", tag, n, led_out, e ^ pol[0]);
          end
          checks++;
          if (progress !== 1'b1) begin
            errors++;
            $display("FAIL %s progress_high[%0d]: got %b required 1", tag, n, progress);
          end
          n++;
          if (n == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (progress !== 1'b0 || cs_n !== 1'b1 || addr !== 4'd0 || led_out !== 1'b0) begin
              errors++;
              $display("FAIL %s async_reset: progress=%b cs_n=%b addr=%0d led_out=%b required 0 1 0 0",
                       tag, progress, cs_n, addr, led_out);
            end
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            early_exit = 1;
            break;
          end
          if (n == abort_at) begin
            controller_en = 1'b0;
            aborting = 1;
          end
        end else begin
          checks++;
          if (progress !== 1'b0 || led_out !== pol[0]) begin
            errors++;
            $display("FAIL %s end: progress=%b led_out=%b required 0 %b",
                     tag, progress, led_out, pol[0]);
          end
          finished = 1;
          break;
        end
      end else if (k > 40) begin
        break;
      end
    end
    start = 1'b0;
    if (early_exit) begin
      exp_addr.delete();
      exp_led.delete();
    end else begin
      checks++;
      if (!finished || exp_addr.size() != 0) begin
        errors++;
        $display("FAIL %s completion: finished=%b fetches_left=%0d required 1 0",
                 tag, finished, exp_addr.size());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (progress !== 1'b0) begin errors++; $display("FAIL reset progress: got %b required 0", progress); end
    checks++;
    if (cs_n !== 1'b1) begin errors++; $display("FAIL reset cs_n: got %b required 1", cs_n); end
    checks++;
    if (addr !== 4'd0) begin errors++; $display("FAIL reset addr: got %0d required 0", addr); end
    checks++;
    if (led_out !== 1'b0) begin errors++; $display("FAIL reset led_out: got %b required 0", led_out); end
  endtask

  task automatic test_single_byte();
    mem[0] = 8'hA5;
    run_case("single", 1, 0, 0, 0, 0, -1, -1, -1);
  endtask

  task automatic test_multi_repeat();
    mem[4] = 8'hFF; mem[5] = 8'h00; mem[6] = 8'h81;
    run_case("multi", 0, 0, 4, 6, 1, -1, -1, -1);
  endtask

  task automatic test_polarity();
    polarity = 1'b1;
    @(negedge clk);
    checks++;
    if (led_out !== 1'b1) begin
      errors++;
      $display("FAIL polarity idle: got %b required 1", led_out);
    end
    run_case("polarity", 1, 1, 0, 0, 0, -1, -1, -1);
  endtask

  task automatic test_addr_wrap();
    mem[14] = 8'h3C; mem[15] = 8'hC3; mem[0] = 8'h01; mem[1] = 8'h80;
    run_case("wrap", 0, 0, 14, 1, 0, -1, -1, -1);
  endtask

  task automatic test_abort_ignored_start();
    mem[8] = 8'h55; mem[9] = 8'hAA; mem[10] = 8'hF0;
    run_case("abort", 1, 0, 8, 10, 0, 60, 10, -1);
    controller_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (progress !== 1'b0 || cs_n !== 1'b1) begin
      errors++;
      $display("FAIL start_disabled: progress=%b cs_n=%b required 0 1", progress, cs_n);
    end
    controller_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    mem[5] = 8'h96; mem[6] = 8'h69;
    run_case("rst_mid", 1, 0, 5, 6, 0, -1, -1, 20);
    mem[0] = 8'hA5;
    run_case("after_rst", 1, 0, 0, 0, 0, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    mem[3] = 8'h4B; mem[7] = 8'hE2;
    run_case("b2b_a", 0, 0, 7, 7, 0, -1, -1, -1);
    run_case("b2b_b", 2, 0, 3, 3, 2, -1, -1, -1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
    test_reset();
    test_single_byte();
    test_multi_repeat();
    test_polarity();
    test_addr_wrap();
    test_abort_ignored_start();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
